irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 4, number of interrupt channels, legal range 1..16.
REQ-002 Parameter IRQ_VEC, default 32'h8000_0004, handler entry PC for interrupts.
REQ-003 Parameter EXC_VEC, default 32'h8000_0008, handler entry PC for illegal-instruction exceptions.
REQ-004 clk  in  1  sole clock, all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 irq_in  in  NUM_IRQ  raw interrupt request lines.
REQ-007 mask_we / mask_wdata  in  1 / NUM_IRQ  write strobe and data for the enable mask.
REQ-008 exc_in  in  1  illegal-opcode flag from the decoder for the instruction currently in ID.
REQ-009 id_valid / id_pc / stall  in  1 / 32 / 1  ID-stage instruction valid, its PC, and pipeline stall.
REQ-010 kernel / eret  in  1 / 1  PC[31] of the ID instruction, and return-from-handler decode (jr $k0).
REQ-011 flush / vec_pc  out  1 / 32  squash IF/ID and redirect the PC to vec_pc.
REQ-012 epc / cause  out  32 / 5  saved return PC; cause[4]=exception, cause[3:0]=IRQ index.
REQ-013 irq_ack / busy / mask  out  NUM_IRQ / 1 / NUM_IRQ  one-hot ack pulse, handler active, current mask.

Function
REQ-014 A rising edge on irq_in[i], detected against a one-cycle registered copy, SHALL set pending[i] at the next clock edge.
REQ-015 The eligible set SHALL be pending & mask, and the lowest eligible index SHALL have highest priority.
REQ-016 The FSM SHALL have three states: IDLE, FLUSH and HANDLER.
REQ-017 In IDLE, an entry SHALL be taken when id_valid=1, kernel=0, stall=0, and either the eligible set is non-zero or exc_in=1.
REQ-018 An interrupt SHALL take priority over exc_in when both are present in the same cycle.
REQ-019 On entry the FSM SHALL latch epc<=id_pc and cause<={1'b0,index} or {1'b1,4'h0}, then move to FLUSH.
REQ-020 In FLUSH, for exactly one cycle, flush=1 and vec_pc=IRQ_VEC or EXC_VEC.
REQ-021 In FLUSH, for that interrupt entry only, irq_ack SHALL assert on the taken bit and pending of that bit SHALL clear.
REQ-022 The FSM SHALL move from FLUSH to HANDLER unconditionally on the next edge.
REQ-023 In HANDLER, busy=1, no new entry SHALL be taken (no nesting), and pending bits SHALL continue to accumulate.
REQ-024 The FSM SHALL return from HANDLER to IDLE on a cycle with id_valid=1, eret=1, kernel=1 and stall=0; an eret seen in IDLE is ignored.
REQ-025 If a new edge and an ack hit the same pending bit in the same cycle, the set SHALL win.
REQ-026 A mask_we=1 write SHALL update mask at the next edge; masked pending bits SHALL be retained, not dropped.
REQ-027 A stall=1 cycle in IDLE SHALL defer entry without losing pending state.
REQ-028 Entry latency SHALL be: irq edge at cycle N gives pending at N+1, earliest entry at N+1, and flush at N+2.
REQ-029 flush and irq_ack SHALL be 0 in all states other than FLUSH.
REQ-030 vec_pc SHALL hold its last value outside FLUSH.

Reset
REQ-031 On reset the block SHALL set state=IDLE, pending=0, the edge register=0, mask=all ones, epc=0, cause=0, and flush/irq_ack/busy=0.
REQ-032 A reset in FLUSH or HANDLER SHALL return the block to IDLE on the next edge with all pending state discarded.

Configuration
REQ-033 With IRQ_SYNC_EN defined, irq_in SHALL pass a two-flop synchronizer before edge detection, adding 2 cycles to REQ-028 (flush at N+4).
REQ-034 Without IRQ_SYNC_EN, irq_in SHALL feed edge detection directly.

Structure
REQ-035 Package irq_ctrl_pkg SHALL hold the FSM state enum, CAUSE_W=5, the CAUSE_EXC bit position, and the default IRQ_VEC/EXC_VEC constants.
REQ-036 Sub-module irq_prio_enc SHALL be parametrised by NUM_IRQ and output any-valid plus a 4-bit lowest-set index.

Verification
REQ-037 irq_in[2] rises at cycle 10 with id_valid=1, kernel=0, id_pc=32'h0040_0020 -> flush=1 at 12, vec_pc=32'h8000_0004, epc=32'h0040_0020, cause=5'h02, irq_ack=4'b0100.
REQ-038 irq_in[1] and irq_in[3] rise together with mask=4'b1111 -> cause=5'h01 first; after eret, the second entry gives cause=5'h03.
REQ-039 exc_in=1 and irq_in[0] rising land in the same entry cycle -> cause=5'h00; after eret, exc_in held -> cause=5'h10, vec_pc=32'h8000_0008, irq_ack=0.
REQ-040 mask=4'b0000, then irq_in[0] pulses, then mask=4'b0001 is written -> no entry while masked; entry occurs after the write.
REQ-041 irq_in[1] rises while in HANDLER -> no flush until eret (kernel=1); then flush=1 with cause=5'h01.
REQ-042 reset=1 asserted in HANDLER with pending=4'b1000 -> next cycle busy=0, pending=0, mask=4'hF, and no spurious flush.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt/exception controller.
// Optional IRQ_SYNC_EN build macro is consumed by irq_ctrl.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_HANDLER = 2'd2
  } state_e;

  localparam int CAUSE_W   = 5;
  localparam int CAUSE_EXC = 4;

  localparam logic [31:0] DEF_IRQ_VEC = 32'h8000_0004;
  localparam logic [31:0] DEF_EXC_VEC = 32'h8000_0008;

  // cause[CAUSE_EXC] flags an exception; the low nibble carries the IRQ index.
  function automatic logic [CAUSE_W-1:0] make_cause(input logic is_exc, input logic [3:0] index);
    logic [CAUSE_W-1:0] c;
    c            = {1'b0, index};
    c[CAUSE_EXC] = is_exc;
    return c;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder for the eligible interrupt set.
module irq_prio_enc #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [3:0]         index
);

  always_comb begin
    valid = |req;
    index = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) index = 4'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt/exception entry controller: edge-detected pending bits, masked
// priority selection and a three-state entry FSM. Build macro: IRQ_SYNC_EN.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NUM_IRQ = 4,
  parameter logic [31:0] IRQ_VEC = DEF_IRQ_VEC,
  parameter logic [31:0] EXC_VEC = DEF_EXC_VEC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               exc_in,
  input  logic               id_valid,
  input  logic [31:0]        id_pc,
  input  logic               stall,
  input  logic               kernel,
  input  logic               eret,
  output logic               flush,
  output logic [31:0]        vec_pc,
  output logic [31:0]        epc,
  output logic [CAUSE_W-1:0] cause,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               busy,
  output logic [NUM_IRQ-1:0] mask
);

  state_e               state_reg, state_next;
  logic [NUM_IRQ-1:0]   irq_src;
  logic [NUM_IRQ-1:0]   irq_prev_reg;
  logic [NUM_IRQ-1:0]   irq_rise;
  logic [NUM_IRQ-1:0]   pending_reg, pending_next;
  logic [NUM_IRQ-1:0]   mask_reg;
  logic [NUM_IRQ-1:0]   eligible;
  logic [NUM_IRQ-1:0]   elig_onehot;
  logic [NUM_IRQ-1:0]   ack_sel_reg;
  logic                 any_elig;
  logic [3:0]           elig_idx;
  logic                 take_entry;
  logic                 take_return;
  logic [31:0]          epc_reg;
  logic [31:0]          vec_pc_reg;
  logic [CAUSE_W-1:0]   cause_reg;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_reg, sync2_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= irq_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign irq_src = sync2_reg;
`else
  assign irq_src = irq_in;
`endif

  assign irq_rise = irq_src & ~irq_prev_reg;
  assign eligible = pending_reg & mask_reg;

  irq_prio_enc #(
    .NUM_IRQ(NUM_IRQ)
  ) u_prio (
    .req  (eligible),
    .valid(any_elig),
    .index(elig_idx)
  );

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_onehot
    assign elig_onehot[gi] = (elig_idx == 4'(gi));
  end

  assign take_entry  = (state_reg == ST_IDLE) && id_valid && !kernel && !stall
                       && (any_elig || exc_in);
  assign take_return = (state_reg == ST_HANDLER) && id_valid && eret && kernel && !stall;

  assign irq_ack = (state_reg == ST_FLUSH) ? ack_sel_reg : '0;
  // A fresh edge re-arms a bit even when it is being acknowledged this cycle.
  assign pending_next = (pending_reg & ~irq_ack) | irq_rise;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (take_entry) state_next = ST_FLUSH;
      ST_FLUSH:   state_next = ST_HANDLER;
      ST_HANDLER: if (take_return) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      irq_prev_reg <= '0;
      pending_reg  <= '0;
      mask_reg     <= '1;
      epc_reg      <= '0;
      cause_reg    <= '0;
      vec_pc_reg   <= '0;
      ack_sel_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      irq_prev_reg <= irq_src;
      pending_reg  <= pending_next;
      if (mask_we) mask_reg <= mask_wdata;
      if (take_entry) begin
        epc_reg <= id_pc;
        if (any_elig) begin
          cause_reg   <= make_cause(1'b0, elig_idx);
          vec_pc_reg  <= IRQ_VEC;
          ack_sel_reg <= elig_onehot;
        end else begin
          cause_reg   <= make_cause(1'b1, 4'h0);
          vec_pc_reg  <= EXC_VEC;
          ack_sel_reg <= '0;
        end
      end
    end
  end

  assign flush  = (state_reg == ST_FLUSH);
  assign busy   = (state_reg == ST_HANDLER);
  assign vec_pc = vec_pc_reg;
  assign epc    = epc_reg;
  assign cause  = cause_reg;
  assign mask   = mask_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus random traffic
// checked every cycle against a behavioural model of the controller.
module tb_irq_ctrl;

  localparam int          N   = 4;
  localparam logic [31:0] IVEC = 32'h8000_0004;
  localparam logic [31:0] EVEC = 32'h8000_0008;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_in;
  logic          mask_we;
  logic [N-1:0]  mask_wdata;
  logic          exc_in;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic          stall;
  logic          kernel;
  logic          eret;
  logic          flush;
  logic [31:0]   vec_pc;
  logic [31:0]   epc;
  logic [4:0]    cause;
  logic [N-1:0]  irq_ack;
  logic          busy;
  logic [N-1:0]  mask;

  int errors = 0;
  int checks = 0;

  irq_ctrl #(.NUM_IRQ(N)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .exc_in(exc_in), .id_valid(id_valid),
    .id_pc(id_pc), .stall(stall), .kernel(kernel), .eret(eret),
    .flush(flush), .vec_pc(vec_pc), .epc(epc), .cause(cause),
    .irq_ack(irq_ack), .busy(busy), .mask(mask)
  );

  always #5 clk = ~clk;

  // Behavioural model: "vectoring" is the one-cycle redirect, "in_handler" the handler body.
  bit           m_vectoring, m_in_handler;
  logic [N-1:0] m_last, m_s1, m_s2, m_pend, m_mask, m_take;
  logic [31:0]  m_epc, m_vec;
  logic [4:0]   m_cause;

  task automatic model_update();
    logic [N-1:0] src, rise, elig, acked;
    int lowest;
    if (reset) begin
      m_vectoring = 0; m_in_handler = 0;
      m_last = '0; m_s1 = '0; m_s2 = '0; m_pend = '0; m_mask = '1;
      m_take = '0; m_epc = '0; m_vec = '0; m_cause = '0;
      return;
    end
`ifdef IRQ_SYNC_EN
    src = m_s2;
`else
    src = irq_in;
`endif
    rise   = src & ~m_last;
    elig   = m_pend & m_mask;
    acked  = m_vectoring ? m_take : '0;
    m_pend = (m_pend & ~acked) | rise;
    m_last = src;
    m_s2   = m_s1;
    m_s1   = irq_in;
    if (mask_we) m_mask = mask_wdata;
    if (m_vectoring) begin
      m_vectoring  = 0;
      m_in_handler = 1;
    end else if (m_in_handler) begin
      if (id_valid && eret && kernel && !stall) m_in_handler = 0;
    end else if (id_valid && !kernel && !stall && (elig != 0 || exc_in)) begin
      m_epc = id_pc;
      m_vectoring = 1;
      if (elig != 0) begin
        lowest = 0;
        for (int i = N - 1; i >= 0; i--) if (elig[i]) lowest = i;
        m_cause = 5'(lowest);
        m_vec   = IVEC;
        m_take  = N'(1) << lowest;
      end else begin
        m_cause = 5'h10;
        m_vec   = EVEC;
        m_take  = '0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("flush",   32'(flush),   32'(m_vectoring));
    chk("irq_ack", 32'(irq_ack), 32'(m_vectoring ? m_take : '0));
    chk("busy",    32'(busy),    32'(m_in_handler));
    chk("vec_pc",  vec_pc,       m_vec);
    chk("epc",     epc,          m_epc);
    chk("cause",   32'(cause),   32'(m_cause));
    chk("mask",    32'(mask),    32'(m_mask));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_eret();
    kernel = 1; eret = 1;
    tick();
    kernel = 0; eret = 0;
  endtask

  initial begin
    reset = 1; irq_in = '0; mask_we = 0; mask_wdata = '0; exc_in = 0;
    id_valid = 0; id_pc = '0; stall = 0; kernel = 0; eret = 0;
    ticks(2);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_mask",  32'(mask),  32'hF);
    chk("rst_cause", 32'(cause), 32'd0);
    chk("rst_epc",   epc,        32'd0);
    reset = 0;
    id_valid = 1; id_pc = 32'h0040_0020;
    ticks(3);

    // Single interrupt on line 2.
    irq_in = 4'b0100;
    ticks(LAT - 1);
    chk("lat_no_flush_yet", 32'(flush), 32'd0);
    tick();
    chk("r37_flush",  32'(flush),   32'd1);
    chk("r37_vec",    vec_pc,       32'h8000_0004);
    chk("r37_epc",    epc,          32'h0040_0020);
    chk("r37_cause",  32'(cause),   32'h02);
    chk("r37_ack",    32'(irq_ack), 32'b0100);
    tick();
    chk("r37_busy", 32'(busy), 32'd1);
    irq_in = '0;
    do_eret();

    // Two simultaneous edges: lowest first, the other after eret.
    irq_in = 4'b1010;
    ticks(LAT);
    chk("r38_cause1", 32'(cause), 32'h01);
    tick();
    do_eret();
    tick();
    chk("r38_flush2", 32'(flush), 32'd1);
    chk("r38_cause2", 32'(cause), 32'h03);
    tick();
    irq_in = '0;
    do_eret();

    // Interrupt beats a simultaneous exception; the exception follows after eret.
    irq_in = 4'b0001;
    ticks(LAT - 1);
    exc_in = 1;
    tick();
    chk("r39_cause_irq", 32'(cause), 32'h00);
    chk("r39_ack_irq",   32'(irq_ack), 32'b0001);
    tick();
    do_eret();
    exc_in = 1;
    tick();
    chk("r39_cause_exc", 32'(cause),   32'h10);
    chk("r39_vec_exc",   vec_pc,       32'h8000_0008);
    chk("r39_ack_exc",   32'(irq_ack), 32'd0);
    exc_in = 0;
    tick();
    do_eret();

    // Masked pending bit is retained and taken once unmasked.
    mask_we = 1; mask_wdata = 4'b0000;
    tick();
    mask_we = 0;
    irq_in = 4'b0000; tick();
    irq_in = 4'b0001; tick();
    irq_in = 4'b0000;
    ticks(6);
    chk("r40_masked_no_flush", 32'(flush), 32'd0);
    mask_we = 1; mask_wdata = 4'b0001;
    tick();
    mask_we = 0;
    tick();
    chk("r40_flush_after_unmask", 32'(flush), 32'd1);
    chk("r40_cause", 32'(cause), 32'h00);
    tick();
    do_eret();
    mask_we = 1; mask_wdata = 4'hF; tick(); mask_we = 0;

    // No nesting: an edge during the handler waits for eret.
    exc_in = 1; tick(); exc_in = 0; tick();
    irq_in = 4'b0010;
    ticks(6);
    chk("r41_no_nest_flush", 32'(flush), 32'd0);
    chk("r41_still_busy",    32'(busy),  32'd1);
    do_eret();
    tick();
    chk("r41_flush",  32'(flush), 32'd1);
    chk("r41_cause",  32'(cause), 32'h01);
    tick();

    // Stall defers entry without losing the pending bit.
    irq_in = '0; do_eret();
    stall = 1; irq_in = 4'b0100;
    ticks(LAT + 3);
    chk("stall_no_flush", 32'(flush), 32'd0);
    stall = 0;
    tick();
    chk("stall_then_flush", 32'(flush), 32'd1);
    tick();
    irq_in = '0;

    // Reset in the handler discards pending work and restores the mask.
    mask_we = 1; mask_wdata = 4'b1001; tick(); mask_we = 0;
    irq_in = 4'b1000;
    ticks(6);
    reset = 1; irq_in = '0;
    tick();
    reset = 0;
    chk("r42_busy",  32'(busy),  32'd0);
    chk("r42_mask",  32'(mask),  32'hF);
    chk("r42_flush", 32'(flush), 32'd0);
    ticks(4);
    chk("r42_no_spurious", 32'(flush), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = 4'($urandom);
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = 4'($urandom);
      exc_in     = ($urandom_range(0, 7) == 0);
      id_valid   = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 4) == 0);
      kernel     = ($urandom_range(0, 2) == 0);
      eret       = ($urandom_range(0, 2) == 0);
      id_pc      = $urandom;
      reset      = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
